// File: rtl/ofdm_rx_symbol_sequencer_if.sv
// Sample-stream bundle around the OFDM RX symbol sequencer.
// The serializer drives in_*, the downstream CP-removal stage drives out_ready.
interface ofdm_rx_symbol_sequencer_if #(
  parameter int IDX_W = 4
) ();
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic [15:0]      out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_ready;

  // Environment side: serializer plus downstream consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/ofdm_rx_symbol_sequencer.sv
// OFDM RX symbol sequencer: splits the serializer stream into useful-sample
// and cyclic-prefix windows per symbol, forwards only useful samples.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; nothing accepted
// DATA  | useful samples, forwarded downstream under valid/ready
// CP    | cyclic-prefix samples, always accepted and discarded
module ofdm_rx_symbol_sequencer #(
  parameter int N_FFT    = 16,
  parameter int CP_MAX   = 8,
  parameter int CP_FIRST = 0,
  parameter int SYM_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(CP_MAX+1)-1:0]  cfg_cp_len,
  input  logic [SYM_W-1:0]             cfg_num_sym,
  ofdm_rx_symbol_sequencer_if.slave    io,
  output logic                         sym_done,
  output logic                         frame_done,
  output logic [SYM_W-1:0]             sym_cnt,
  output logic                         busy,
  output logic                         start_ignored
);

  localparam int IDX_W = $clog2(N_FFT);
  localparam int CPW   = $clog2(CP_MAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_CP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] data_cnt_q, data_cnt_d;
  logic [CPW-1:0]   cp_cnt_q, cp_cnt_d;
  logic [CPW-1:0]   cp_len_q, cp_len_d;
  logic [SYM_W-1:0] num_sym_q, num_sym_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             sym_done_q, sym_done_d;
  logic             frame_done_q, frame_done_d;
  logic             start_ign_q, start_ign_d;

  logic             in_ready_c;
  logic             out_valid_c;
  logic             sym_complete;
  logic [CPW-1:0]   cp_len_clamped;
  logic [1:0]       first_phase;

  // Clamp the requested CP length to what the counter is sized for.
  always_comb begin
    cp_len_clamped = cfg_cp_len;
    if (cfg_cp_len > CPW'(CP_MAX)) cp_len_clamped = CPW'(CP_MAX);
  end

  // Opening phase of every symbol after the first, using the latched CP length.
  always_comb begin
    first_phase = S_DATA;
    if ((CP_FIRST != 0) && (cp_len_q != '0)) first_phase = S_CP;
  end

  // Next-state, handshake and counter logic.
  always_comb begin
    state_d      = state_q;
    data_cnt_d   = data_cnt_q;
    cp_cnt_d     = cp_cnt_q;
    cp_len_d     = cp_len_q;
    num_sym_d    = num_sym_q;
    sym_cnt_d    = sym_cnt_q;
    sym_done_d   = 1'b0;
    frame_done_d = 1'b0;
    start_ign_d  = start_ign_q;
    in_ready_c   = 1'b0;
    out_valid_c  = 1'b0;
    sym_complete = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          cp_len_d    = cp_len_clamped;
          num_sym_d   = (cfg_num_sym == '0) ? SYM_W'(1) : cfg_num_sym;
          sym_cnt_d   = '0;
          data_cnt_d  = '0;
          cp_cnt_d    = '0;
          start_ign_d = 1'b0;
          state_d     = ((CP_FIRST != 0) && (cp_len_clamped != '0)) ? S_CP : S_DATA;
        end
      end
      S_DATA: begin
        out_valid_c = io.in_valid;
        in_ready_c  = io.out_ready;
        if (io.in_valid && io.out_ready) begin
          if (data_cnt_q == IDX_W'(N_FFT - 1)) begin
            data_cnt_d = '0;
            if ((CP_FIRST == 0) && (cp_len_q != '0)) state_d = S_CP;
            else                                     sym_complete = 1'b1;
          end else begin
            data_cnt_d = data_cnt_q + IDX_W'(1);
          end
        end
      end
      S_CP: begin
        in_ready_c = 1'b1;
        if (io.in_valid) begin
          if (cp_cnt_q == cp_len_q - CPW'(1)) begin
            cp_cnt_d = '0;
            if (CP_FIRST != 0) state_d = S_DATA;
            else               sym_complete = 1'b1;
          end else begin
            cp_cnt_d = cp_cnt_q + CPW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sym_complete) begin
      sym_cnt_d  = sym_cnt_q + SYM_W'(1);
      sym_done_d = 1'b1;
      if (sym_cnt_q == num_sym_q - SYM_W'(1)) begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end else begin
        state_d = first_phase;
      end
    end

    if (start && (state_q != S_IDLE)) start_ign_d = 1'b1;

    // Abort overrides everything, including a symbol completing this cycle.
    if (abort) begin
      state_d      = S_IDLE;
      data_cnt_d   = '0;
      cp_cnt_d     = '0;
      sym_cnt_d    = '0;
      sym_done_d   = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      data_cnt_q   <= '0;
      cp_cnt_q     <= '0;
      cp_len_q     <= '0;
      num_sym_q    <= '0;
      sym_cnt_q    <= '0;
      sym_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      start_ign_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_cnt_q   <= data_cnt_d;
      cp_cnt_q     <= cp_cnt_d;
      cp_len_q     <= cp_len_d;
      num_sym_q    <= num_sym_d;
      sym_cnt_q    <= sym_cnt_d;
      sym_done_q   <= sym_done_d;
      frame_done_q <= frame_done_d;
      start_ign_q  <= start_ign_d;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_c;
  assign io.out_data  = io.in_data;
  assign io.out_idx   = data_cnt_q;
  assign io.out_last  = (state_q == S_DATA) && (data_cnt_q == IDX_W'(N_FFT - 1));

  assign sym_done      = sym_done_q;
  assign frame_done    = frame_done_q;
  assign sym_cnt       = sym_cnt_q;
  assign busy          = (state_q != S_IDLE);
  assign start_ignored = start_ign_q;

endmodule
